fetch_sequencer: RTL and testbench

//  Owns the PC and drives the instruction-memory port. It presents fetched words to decode over a valid/ready handshake.

---
 rtl/fetch_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer
// ----------------------------------------------------------------------------
// Owns the program counter and drives the instruction-memory port. Fetched
// words are handed to decode over a valid/ready handshake. Branch and jump
// redirects from decode/execute are applied here. Any fetch that a redirect
// makes stale is squashed, whether it is still in flight or already held.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   CNT_W        width of the performance counters
//
// Ports
//   clock        single clock; all state updates on posedge
//   reset        synchronous, active-high
//   imem_req     fetch request level to instruction memory
//   imem_addr    word-aligned byte address; stable while imem_req until ack
//   imem_ack     1-cycle pulse: imem_rdata valid this cycle
//   imem_rdata   instruction word from memory
//   if_valid     if_instr/if_pc/if_pc4 hold a live instruction
//   id_ready     decode accepts when if_valid & id_ready
//   if_instr     fetched instruction
//   if_pc        address of if_instr
//   if_pc4       if_pc + 4
//   do_branch    redirect to branch_addr (wins over jump)
//   branch_addr  branch target
//   jump         redirect to {fetch_pc[31:28], jump_index, 2'b00}
//   jump_index   jump instruction index field
//   instr_count  instructions accepted by decode
//   wait_cycles  cycles spent waiting on memory (REQ or DROP, no ack)
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc4,
    input  logic             do_branch,
    input  logic [31:0]      branch_addr,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] wait_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        pend_pc_q,  pend_pc_d;
    logic               req_q,      req_d;
    logic [31:0]        addr_q,     addr_d;
    logic               valid_q,    valid_d;
    logic [31:0]        instr_q,    instr_d;
    logic [31:0]        ifpc_q,     ifpc_d;
    logic [31:0]        ifpc4_q,    ifpc4_d;
    logic [CNT_W-1:0]   icnt_q,     icnt_d;
    logic [CNT_W-1:0]   wcnt_q,     wcnt_d;

    logic               redirect;
    logic [31:0]        target;

    always_comb begin
        redirect = do_branch | jump;
        // Branch target is forced to a word boundary so fetch_pc[1:0] stays 0.
        if (do_branch) begin
            target = branch_addr & ~32'h3;
        end else begin
            target = {fetch_pc_q[31:28], jump_index, 2'b00};
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ifpc_d     = ifpc_q;
        ifpc4_d    = ifpc4_q;
        icnt_d     = icnt_q;
        wcnt_d     = wcnt_q;

        if ((state_q == REQ || state_q == DROP) && !imem_ack) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                fetch_pc_d = redirect ? target : fetch_pc_q;
                req_d      = 1'b1;
                addr_d     = fetch_pc_d;
                state_d    = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word is already stale: refetch from target.
                        fetch_pc_d = target;
                        addr_d     = target;
                        req_d      = 1'b1;
                    end else begin
                        instr_d = imem_rdata;
                        ifpc_d  = fetch_pc_q;
                        ifpc4_d = fetch_pc_q + 32'd4;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // Request cannot be withdrawn; remember where to go once it completes.
                    pend_pc_d = target;
                    state_d   = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    fetch_pc_d = redirect ? target : pend_pc_q;
                    addr_d     = fetch_pc_d;
                    req_d      = 1'b1;
                    state_d    = REQ;
                end else if (redirect) begin
                    pend_pc_d = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    if (id_ready) begin
                        icnt_d = icnt_q + CNT_W'(1);
                    end
                    valid_d    = 1'b0;
                    fetch_pc_d = target;
                    addr_d     = target;
                    req_d      = 1'b1;
                    state_d    = REQ;
                end else if (id_ready) begin
                    icnt_d     = icnt_q + CNT_W'(1);
                    valid_d    = 1'b0;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    addr_d     = fetch_pc_d;
                    req_d      = 1'b1;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            ifpc_q     <= RESET_PC;
            ifpc4_q    <= RESET_PC + 32'd4;
            icnt_q     <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ifpc_q     <= ifpc_d;
            ifpc4_q    <= ifpc4_d;
            icnt_q     <= icnt_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign if_pc4      = ifpc4_q;
    assign instr_count = icnt_q;
    assign wait_cycles = wcnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] MAGIC = 32'h5A5A_A5A5;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        do_branch;
    logic [31:0] branch_addr;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr_count;
    logic [31:0] wait_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    // Memory returns an address-derived word so a latched instruction identifies its fetch.
    assign imem_rdata = imem_addr ^ MAGIC;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .do_branch   (do_branch),
        .branch_addr (branch_addr),
        .jump        (jump),
        .jump_index  (jump_index),
        .instr_count (instr_count),
        .wait_cycles (wait_cycles)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        br;
        logic [31:0] baddr;
        logic        jmp;
        logic [25:0] jidx;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ic;
        logic [31:0] wc;
    } vec_t;

    vec_t tv[$];

    task automatic v(input logic rst, input logic ack, input logic rdy,
                     input logic br, input logic [31:0] baddr,
                     input logic jmp, input logic [25:0] jidx,
                     input logic req, input logic [31:0] addr,
                     input logic vld, input logic [31:0] pc,
                     input logic [31:0] ic, input logic [31:0] wc);
        vec_t e;
        e.rst = rst; e.ack = ack; e.rdy = rdy; e.br = br; e.baddr = baddr;
        e.jmp = jmp; e.jidx = jidx; e.req = req; e.addr = addr; e.vld = vld;
        e.pc = pc; e.ic = ic; e.wc = wc;
        tv.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic ack, input logic rdy,
                         input logic br, input logic [31:0] baddr,
                         input logic jmp, input logic [25:0] jidx);
        reset = rst; imem_ack = ack; id_ready = rdy;
        do_branch = br; branch_addr = baddr; jump = jmp; jump_index = jidx;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);

        //  rst ack rdy br baddr          jmp jidx     | req addr           vld pc             ic wc
        // reset and first request
        v(1, 0, 0, 0, 32'h0,          0, 26'h0,     0, 32'h0,          0, 32'h0,          0, 0);
        v(0, 0, 0, 0, 32'h0,          0, 26'h0,     1, 32'h0,          0, 32'h0,          0, 0);
        // zero-wait memory, decode always ready
        v(0, 1, 1, 0, 32'h0,          0, 26'h0,     0, 32'h0,          1, 32'h0,          0, 0);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h4,          0, 32'h0,          1, 0);
        v(0, 1, 1, 0, 32'h0,          0, 26'h0,     0, 32'h4,          1, 32'h4,          1, 0);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h8,          0, 32'h4,          2, 0);
        v(0, 1, 1, 0, 32'h0,          0, 26'h0,     0, 32'h8,          1, 32'h8,          2, 0);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'hC,          0, 32'h8,          3, 0);
        v(0, 1, 1, 0, 32'h0,          0, 26'h0,     0, 32'hC,          1, 32'hC,          3, 0);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h10,         0, 32'hC,          4, 0);
        // three wait cycles before ack
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h10,         0, 32'hC,          4, 1);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h10,         0, 32'hC,          4, 2);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h10,         0, 32'hC,          4, 3);
        v(0, 1, 1, 0, 32'h0,          0, 26'h0,     0, 32'h10,         1, 32'h10,         4, 3);
        // decode stalls five cycles
        for (int k = 0; k < 5; k++)
            v(0, 0, 0, 0, 32'h0,      0, 26'h0,     0, 32'h10,         1, 32'h10,         4, 3);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h14,         0, 32'h10,         5, 3);
        // branch while request waiting -> DROP, stale word hidden
        v(0, 0, 0, 1, 32'h40,         0, 26'h0,     1, 32'h14,         0, 32'h10,         5, 4);
        v(0, 0, 0, 0, 32'h0,          0, 26'h0,     1, 32'h14,         0, 32'h10,         5, 5);
        v(0, 1, 0, 0, 32'h0,          0, 26'h0,     1, 32'h40,         0, 32'h10,         5, 5);
        v(0, 1, 1, 0, 32'h0,          0, 26'h0,     0, 32'h40,         1, 32'h40,         5, 5);
        // branch in HOLD without ready, then branch+jump together
        v(0, 0, 0, 1, 32'h1000_0010,  0, 26'h0,     1, 32'h1000_0010,  0, 32'h40,         5, 5);
        v(0, 1, 0, 0, 32'h0,          0, 26'h0,     0, 32'h1000_0010,  1, 32'h1000_0010,  5, 5);
        v(0, 0, 0, 1, 32'h80,         1, 26'h3,     1, 32'h80,         0, 32'h1000_0010,  5, 5);
        // ack coinciding with redirect: data discarded, refetch target
        v(0, 1, 0, 1, 32'h1000_0010,  0, 26'h0,     1, 32'h1000_0010,  0, 32'h1000_0010,  5, 5);
        v(0, 1, 0, 0, 32'h0,          0, 26'h0,     0, 32'h1000_0010,  1, 32'h1000_0010,  5, 5);
        // jump alone in HOLD with ready: handshake still counts
        v(0, 0, 1, 0, 32'h0,          1, 26'h3,     1, 32'h1000_000C,  0, 32'h1000_0010,  6, 5);
        v(0, 1, 0, 0, 32'h0,          0, 26'h0,     0, 32'h1000_000C,  1, 32'h1000_000C,  6, 5);
        v(0, 0, 1, 0, 32'h0,          0, 26'h0,     1, 32'h1000_0010,  0, 32'h1000_000C,  7, 5);
        // enter DROP, overwrite pending target, then reset mid-DROP
        v(0, 0, 0, 0, 32'h0,          1, 26'h10,    1, 32'h1000_0010,  0, 32'h1000_000C,  7, 6);
        v(0, 0, 0, 1, 32'h200,        0, 26'h0,     1, 32'h1000_0010,  0, 32'h1000_000C,  7, 7);
        v(1, 0, 0, 0, 32'h0,          0, 26'h0,     0, 32'h0,          0, 32'h0,          0, 0);
        v(0, 0, 0, 0, 32'h0,          0, 26'h0,     1, 32'h0,          0, 32'h0,          0, 0);
        // DROP ack with a same-cycle redirect: new target wins over pend_pc
        v(0, 0, 0, 1, 32'h300,        0, 26'h0,     1, 32'h0,          0, 32'h0,          0, 1);
        v(0, 1, 0, 0, 32'h0,          1, 26'h20,    1, 32'h80,         0, 32'h0,          0, 1);
        v(0, 1, 0, 0, 32'h0,          0, 26'h0,     0, 32'h80,         1, 32'h80,         0, 1);
        // redirect during IDLE overrides RESET_PC
        v(1, 0, 0, 0, 32'h0,          0, 26'h0,     0, 32'h0,          0, 32'h0,          0, 0);
        v(0, 0, 0, 1, 32'h500,        0, 26'h0,     1, 32'h500,        0, 32'h0,          0, 0);
        v(0, 1, 0, 0, 32'h0,          0, 26'h0,     0, 32'h500,        1, 32'h500,        0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].ack, tv[i].rdy, tv[i].br, tv[i].baddr, tv[i].jmp, tv[i].jidx);
            tick();
            chk($sformatf("v%0d imem_req", i),    {31'h0, imem_req}, {31'h0, tv[i].req});
            chk($sformatf("v%0d imem_addr", i),   imem_addr,         tv[i].addr);
            chk($sformatf("v%0d if_valid", i),    {31'h0, if_valid}, {31'h0, tv[i].vld});
            chk($sformatf("v%0d if_pc", i),       if_pc,             tv[i].pc);
            chk($sformatf("v%0d if_pc4", i),      if_pc4,            tv[i].pc + 32'd4);
            chk($sformatf("v%0d instr_count", i), instr_count,       tv[i].ic);
            chk($sformatf("v%0d wait_cycles", i), wait_cycles,       tv[i].wc);
            if (tv[i].rst)
                chk($sformatf("v%0d if_instr", i), if_instr, 32'h0);
            else if (tv[i].vld)
                chk($sformatf("v%0d if_instr", i), if_instr, tv[i].pc ^ MAGIC);
        end

        // Hand sequence: accept, then a 3-cycle memory wait with address held.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        tick();
        chk("seq accept req",  {31'h0, imem_req}, 32'h1);
        chk("seq accept addr", imem_addr,         32'h504);
        chk("seq accept ic",   instr_count,       32'h1);
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("seq wait%0d req", k),  {31'h0, imem_req}, 32'h1);
            chk($sformatf("seq wait%0d addr", k), imem_addr,         32'h504);
            chk($sformatf("seq wait%0d vld", k),  {31'h0, if_valid}, 32'h0);
            chk($sformatf("seq wait%0d wc", k),   wait_cycles,       32'(k + 1));
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("seq late vld",   {31'h0, if_valid}, 32'h1);
        chk("seq late pc",    if_pc,             32'h504);
        chk("seq late instr", if_instr,          32'h504 ^ MAGIC);
        chk("seq late req",   {31'h0, imem_req}, 32'h0);

        // Hand sequence: PC +4 wraps at the top of the address space.
        do_branch = 1'b1; branch_addr = 32'hFFFF_FFFC;
        tick();
        do_branch = 1'b0; branch_addr = 32'h0;
        chk("wrap br addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("wrap pc",    if_pc,    32'hFFFF_FFFC);
        chk("wrap pc4",   if_pc4,   32'h0000_0000);
        chk("wrap instr", if_instr, 32'hFFFF_FFFC ^ MAGIC);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("wrap next addr", imem_addr,         32'h0000_0000);
        chk("wrap next req",  {31'h0, imem_req}, 32'h1);
        chk("wrap ic",        instr_count,       32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
